// File: rtl/pe_grid_12x14.sv
// pe_grid_12x14: ROWS x COLS weight-stationary MAC grid with a per-column adder-chain reduction.
// Latency: psum_ins -> psum_outs 1 cycle; a product accumulated at edge k reaches psum_outs at edge k+1.
// Backpressure: none; strobes are consumed every cycle and psum_outs is a free-running register.
module pe_grid_12x14 #(
  parameter int ROWS   = 12,
  parameter int COLS   = 14,
  parameter int DATA_W = 16,
  parameter int PSUM_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] image_val_vec   [0:COLS-1],
  input  logic                     valid_x_vec     [0:COLS-1],
  input  logic signed [DATA_W-1:0] row_weight_vals [0:COLS-1],
  input  logic        [3:0]        tag_row,
  input  logic                     valid_y,
  input  logic signed [PSUM_W-1:0] psum_ins        [0:COLS-1],
  output logic signed [PSUM_W-1:0] psum_outs       [0:COLS-1]
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [DATA_W-1:0] w       [0:ROWS-1][0:COLS-1];
  logic signed [PSUM_W-1:0] acc     [0:ROWS-1][0:COLS-1];
  logic signed [PROD_W-1:0] prod    [0:ROWS-1][0:COLS-1];
  logic signed [PSUM_W-1:0] col_sum [0:COLS-1];

  // Full-precision Q8.8 x Q8.8 -> Q16.16 product of each PE's held weight and its column image.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod[r][c] = PROD_W'(w[r][c]) * PROD_W'(image_val_vec[c]);
      end
    end
  end

  // Column reduction: psum_ins enters at row 0, each row adds its accumulator in turn.
  always_comb begin
    logic signed [PSUM_W-1:0] run;
    for (int c = 0; c < COLS; c++) begin
      run = psum_ins[c];
      for (int r = 0; r < ROWS; r++) begin
        run = run + acc[r][c];
      end
      col_sum[c] = run;
    end
  end

  // Weight load for the tagged row and column-gated MAC; the MAC sees the pre-edge weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w[r][c]   <= '0;
          acc[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (valid_x_vec[c]) begin
            acc[r][c] <= acc[r][c] + PSUM_W'(prod[r][c]);
          end
          if (valid_y && (int'(tag_row) == r)) begin
            w[r][c] <= row_weight_vals[c];
          end
        end
      end
    end
  end

  // Single output register per column, fed from the pre-edge accumulator totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) begin
        psum_outs[c] <= '0;
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        psum_outs[c] <= col_sum[c];
      end
    end
  end

endmodule

// File: tb/tb_pe_grid_12x14.sv
// tb_pe_grid_12x14: directed vector table plus randomized traffic against a column-total model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_pe_grid_12x14;

  localparam int ROWS = 12;
  localparam int COLS = 14;
  localparam int DW   = 16;
  localparam int PW   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] image_val_vec   [0:COLS-1];
  logic                 valid_x_vec     [0:COLS-1];
  logic signed [DW-1:0] row_weight_vals [0:COLS-1];
  logic        [3:0]    tag_row;
  logic                 valid_y;
  logic signed [PW-1:0] psum_ins        [0:COLS-1];
  logic signed [PW-1:0] psum_outs       [0:COLS-1];

  always #5 clk = ~clk;

  pe_grid_12x14 dut (
    .clk             (clk),
    .rst             (rst),
    .image_val_vec   (image_val_vec),
    .valid_x_vec     (valid_x_vec),
    .row_weight_vals (row_weight_vals),
    .tag_row         (tag_row),
    .valid_y         (valid_y),
    .psum_ins        (psum_ins),
    .psum_outs       (psum_outs)
  );

  int checks = 0;
  int errors = 0;

  // Model: weights per PE, and only the running column total (sum over rows of acc).
  logic signed [31:0] mw      [ROWS][COLS];
  logic signed [31:0] colsum  [COLS];
  logic signed [31:0] exp_out [COLS];

  typedef struct {
    logic        vy;
    logic [3:0]  tag;
    logic [15:0] wval;
    logic [13:0] wmask;
    logic [13:0] vxm;
    logic [15:0] x;
    int          col;
    logic [31:0] pin;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mw[r][c] = '0;
    for (int c = 0; c < COLS; c++) begin
      colsum[c]  = '0;
      exp_out[c] = '0;
    end
  endtask

  // A column's accumulators grow by x times the column's weight total on each valid edge.
  task automatic model_edge();
    logic signed [31:0] ws;
    if (rst) begin
      model_clear();
    end else begin
      for (int c = 0; c < COLS; c++) begin
        exp_out[c] = psum_ins[c] + colsum[c];
        if (valid_x_vec[c]) begin
          ws = '0;
          for (int r = 0; r < ROWS; r++) ws = ws + mw[r][c];
          colsum[c] = colsum[c] + ws * image_val_vec[c];
        end
      end
      if (valid_y && int'(tag_row) < ROWS)
        for (int c = 0; c < COLS; c++) mw[tag_row][c] = row_weight_vals[c];
    end
  endtask

  task automatic clr_inputs();
    valid_y = 1'b0;
    tag_row = '0;
    for (int c = 0; c < COLS; c++) begin
      image_val_vec[c]   = '0;
      valid_x_vec[c]     = 1'b0;
      row_weight_vals[c] = '0;
      psum_ins[c]        = '0;
    end
  endtask

  task automatic rand_inputs();
    valid_y = ($urandom_range(0, 3) == 0);
    tag_row = 4'($urandom_range(0, 15));
    for (int c = 0; c < COLS; c++) begin
      image_val_vec[c]   = 16'($urandom);
      valid_x_vec[c]     = 1'($urandom_range(0, 1));
      row_weight_vals[c] = 16'($urandom);
      psum_ins[c]        = 32'($urandom);
    end
  endtask

  task automatic tick_check(input string name);
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < COLS; c++)
      chk($sformatf("%s col%0d", name, c), psum_outs[c], exp_out[c]);
  endtask

  task automatic check_all_zero(input string name);
    for (int c = 0; c < COLS; c++)
      chk($sformatf("%s col%0d", name, c), psum_outs[c], 32'h0);
  endtask

  logic signed [15:0] kw  [6][6];
  logic signed [15:0] img [6][6];
  logic signed [31:0] e;

  initial begin
    rst = 1'b0;
    clr_inputs();
    model_clear();

    // Asynchronous reset with random inputs, then held across edges.
    #2;
    rand_inputs();
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    tick_check("reset_hold");
    rand_inputs();
    tick_check("reset_hold2");
    rst = 1'b0;
    clr_inputs();
    for (int i = 0; i < 3; i++) tick_check("post_reset");

    // Directed vectors: inputs before an edge, expected psum_outs[col] after it.
    tbl[0]  = '{1'b1, 4'd0,  16'h0100, 14'h0003, 14'h0000, 16'h0000, 0, 32'h0, 32'h00000000};
    tbl[1]  = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0001, 16'h0200, 0, 32'h0, 32'h00000000};
    tbl[2]  = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 0, 32'h0, 32'h00020000};
    tbl[3]  = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 3, 32'h0, 32'h00000000};
    tbl[4]  = '{1'b1, 4'd1,  16'h0300, 14'h0002, 14'h0000, 16'h0000, 1, 32'h0, 32'h00000000};
    tbl[5]  = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0002, 16'h0100, 1, 32'h0, 32'h00000000};
    tbl[6]  = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0002, 16'h0100, 1, 32'h0, 32'h00040000};
    tbl[7]  = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 1, 32'h0, 32'h00080000};
    tbl[8]  = '{1'b1, 4'd2,  16'hFF00, 14'h0020, 14'h0000, 16'h0000, 5, 32'h0, 32'h00000000};
    tbl[9]  = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0020, 16'h0200, 5, 32'h0, 32'h00000000};
    tbl[10] = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 5, 32'h0, 32'hFFFE0000};
    tbl[11] = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 5, 32'h00030000, 32'h00010000};
    tbl[12] = '{1'b1, 4'd12, 16'h7FFF, 14'h3FFF, 14'h0000, 16'h0000, 5, 32'h0, 32'hFFFE0000};
    tbl[13] = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h3FFF, 16'h0100, 2, 32'h0, 32'h00000000};
    tbl[14] = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 2, 32'h0, 32'h00000000};
    tbl[15] = '{1'b1, 4'd3,  16'h0200, 14'h0080, 14'h0080, 16'h0100, 7, 32'h0, 32'h00000000};
    tbl[16] = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 7, 32'h0, 32'h00000000};
    tbl[17] = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0080, 16'h0100, 7, 32'h0, 32'h00000000};
    tbl[18] = '{1'b0, 4'd0,  16'h0000, 14'h0000, 14'h0000, 16'h0000, 7, 32'h0, 32'h00020000};

    for (int i = 0; i < 19; i++) begin
      valid_y = tbl[i].vy;
      tag_row = tbl[i].tag;
      for (int c = 0; c < COLS; c++) begin
        row_weight_vals[c] = tbl[i].wmask[c] ? tbl[i].wval : 16'h0;
        valid_x_vec[c]     = tbl[i].vxm[c];
        image_val_vec[c]   = tbl[i].x;
        psum_ins[c]        = (c == tbl[i].col) ? tbl[i].pin : 32'h0;
      end
      tick_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_const", i), psum_outs[tbl[i].col], tbl[i].exp);
    end
    clr_inputs();

    // Reset mid-accumulation discards state immediately.
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    tick_check("reset_mid_edge");
    rst = 1'b0;
    tick_check("reset_mid_release");

    // 6x6 kernel sweep, checked against a direct double sum.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        kw[r][c]  = 16'($urandom);
        img[r][c] = 16'($urandom);
      end
    for (int r = 0; r < 6; r++) begin
      valid_y = 1'b1;
      tag_row = 4'(r);
      for (int c = 0; c < COLS; c++) row_weight_vals[c] = (c < 6) ? kw[r][c] : 16'sh0;
      tick_check("sweep_load");
    end
    clr_inputs();
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 6; c++) begin
        valid_x_vec[c]   = 1'b1;
        image_val_vec[c] = img[k][c];
      end
      tick_check("sweep_valid");
      clr_inputs();
      tick_check("sweep_idle");
    end
    for (int c = 0; c < COLS; c++) begin
      e = '0;
      if (c < 6)
        for (int r = 0; r < 6; r++)
          for (int k = 0; k < 6; k++) e = e + kw[r][c] * img[k][c];
      chk($sformatf("sweep_total col%0d", c), psum_outs[c], e);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        #1;
        check_all_zero("rand_rst_async");
      end
      tick_check("rand");
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_grid_12x14.md
PE_GRID_12X14 -- requirements
Module: pe_grid_12x14

Interface
REQ-001 The module SHALL have one clock, clk, and one reset, rst; rst SHALL be asynchronous and active-high.
REQ-002 Parameter ROWS, default 12, SHALL set the number of PE rows.
REQ-003 Parameter COLS, default 14, SHALL set the number of PE columns.
REQ-004 Parameter DATA_W, default 16, SHALL set the image and weight width, signed Q8.8.
REQ-005 Parameter PSUM_W, default 32, SHALL set the psum width, signed Q16.16.
REQ-006 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-007 rst  input  1  SHALL be the asynchronous active-high reset.
REQ-008 image_val_vec[0:COLS-1]  input  DATA_W each  SHALL be the per-column image value.
REQ-009 valid_x_vec[0:COLS-1]  input  1 each  SHALL be the per-column image-valid strobe.
REQ-010 row_weight_vals[0:COLS-1]  input  DATA_W each  SHALL be one weight per column for the tagged row.
REQ-011 tag_row  input  4  SHALL be the index of the PE row that receives the weights.
REQ-012 valid_y  input  1  SHALL be the weight-load strobe.
REQ-013 psum_ins[0:COLS-1]  input  PSUM_W each  SHALL be the per-column incoming partial sum.
REQ-014 psum_outs[0:COLS-1]  output  PSUM_W each  SHALL be the registered per-column result.

Function
REQ-015 Each PE[r][c] SHALL hold a DATA_W weight register w[r][c] and a PSUM_W accumulator acc[r][c].
REQ-016 On a rising edge with valid_y=1 and tag_row<ROWS, w[tag_row][c] SHALL load row_weight_vals[c] for every c.
REQ-017 A weight load SHALL leave other rows' weights and all accumulators unchanged.
REQ-018 When tag_row>=ROWS, valid_y=1 SHALL have no effect.
REQ-019 On a rising edge with valid_x_vec[c]=1, each of the ROWS PEs in column c SHALL add the signed full-precision product w[r][c]*image_val_vec[c] to acc[r][c].
REQ-020 The product SHALL be Q16.16 in 32 bits, with no shift or rounding.
REQ-021 Accumulation SHALL be two's-complement, wrapping modulo 2^PSUM_W, with no saturation.
REQ-022 When valid_x_vec[c]=0, the accumulators in column c SHALL hold their value.
REQ-023 Columns SHALL be independent; valid_x_vec and image_val_vec of one column SHALL NOT affect any other column.
REQ-024 Each rising edge SHALL register psum_outs[c] = psum_ins[c] + sum over r of acc[r][c], using the accumulator values held before that edge, modulo 2^PSUM_W.
REQ-025 A product accumulated at edge k SHALL first appear on psum_outs at edge k+1.
REQ-026 The psum_ins values sampled at edge k SHALL appear on psum_outs at edge k.
REQ-027 When valid_y and valid_x target the same PE in the same cycle, the multiply SHALL use the weight held before that edge.
REQ-028 The new weight SHALL apply from the next cycle.
REQ-029 Accumulators SHALL clear only on reset; no other clear mechanism SHALL exist.
REQ-030 The column reduction SHALL be implemented as an adder chain from row 0 to row ROWS-1.
REQ-031 psum_ins[c] SHALL enter the chain at row 0, and the result SHALL be registered once at the column output.

Reset
REQ-032 While rst=1, all w, all acc and all psum_outs SHALL be 0, asynchronously, regardless of other inputs.
REQ-033 An assertion of rst mid-accumulation SHALL discard all state immediately.
REQ-034 After rst deasserts, the first rising edge SHALL resume normal operation.
REQ-035 Stimulus applied during reset SHALL be ignored.

Verification
REQ-036 Reset: assert rst with random inputs -> all psum_outs=0x00000000 at once; after release with psum_ins=0 and no strobes, they SHALL stay 0.
REQ-037 Single MAC: load w[0][0]=0x0100 (1.0); pulse valid_x_vec[0] with x=0x0200 -> psum_outs[0]=0x00020000 one edge after the MAC edge; other columns stay 0.
REQ-038 Row reduction: set w[0][1]=0x0100 and w[1][1]=0x0300; pulse x=0x0100 -> psum_outs[1]=0x00040000; a second pulse -> 0x00080000.
REQ-039 Sign: w[2][5]=0xFF00 (-1.0) and x=0x0200 -> psum_outs[5]=0xFFFE0000; with psum_ins[5]=0x00030000 added -> 0x00010000.
REQ-040 Tag guard and overlap: valid_y with tag_row=12 and weights 0x7FFF -> no change to any output after MAC; same-cycle load and MAC -> the old weight is used.
REQ-041 6x6 sweep: load a 6x6 kernel into rows 0-5 and columns 0-5, then inject 6 image rows (valid one cycle, idle one cycle) -> psum_outs[c] = sum over r,k of w[r][c]*img[k][c] after the final idle edge; columns 6-13 = 0.
